// File: rtl/disp_scan_ctrl.sv
// Feeds a two-digit seven-segment driver: shows a 32-bit word one byte at a time,
// MSB first, while free-running anode refresh multiplexes the two hex digits.
module disp_scan_ctrl #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int DWELL_CYCLES   = 100000000,
    parameter int LOOP           = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic [7:0]  char,
    output logic        anode,
    output logic [1:0]  byte_idx,
    output logic        done
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_MAX   = DW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0] RW_ONE      = RW'(1);
    localparam logic [DW-1:0] DW_ONE      = DW'(1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  char_q, char_d;
    logic        anode_q, anode_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= 32'h0;
            refresh_q  <= '0;
            dwell_q    <= '0;
            byte_idx_q <= 2'd3;
            char_q     <= 8'h00;
            anode_q    <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            refresh_q  <= refresh_d;
            dwell_q    <= dwell_d;
            byte_idx_q <= byte_idx_d;
            char_q     <= char_d;
            anode_q    <= anode_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        dwell_d    = dwell_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        anode_d    = anode_q;
        refresh_d  = refresh_q + RW_ONE;

        // Anode phase runs independently of loads and byte changes.
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            anode_d   = ~anode_q;
        end

        // In looping mode a new word preempts the display, including a coincident done.
        load = data_valid && ((state_q == IDLE) || (LOOP != 0));

        if (load) begin
            state_d    = SHOW;
            word_d     = data_in;
            byte_idx_d = 2'd3;
            dwell_d    = '0;
        end else if (state_q == SHOW) begin
            if (dwell_q == DWELL_MAX) begin
                dwell_d = '0;
                if (byte_idx_q != 2'd0) begin
                    byte_idx_d = byte_idx_q - 2'd1;
                end else begin
                    done_d     = 1'b1;
                    byte_idx_d = 2'd3;
                    if (LOOP == 0) begin
                        state_d = IDLE;
                    end
                end
            end else begin
                dwell_d = dwell_q + DW_ONE;
            end
        end

        char_d  = (state_d == SHOW) ? word_d[{byte_idx_d, 3'b000} +: 8] : 8'h00;
        ready_d = (state_d == IDLE) || (LOOP != 0);
    end

    assign data_ready = ready_q;
    assign char       = char_q;
    assign anode      = anode_q;
    assign byte_idx   = byte_idx_q;
    assign done       = done_q;

endmodule
